// File: rtl/id_pipe.sv
// id_pipe: registered RV32I decode stage with EX/MEM operand forwarding and load-use stall.
// Define ID_WB_FWD_EN to add a WB forwarding source for regfiles without write-before-read.
module id_pipe #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [XLEN-1:0]   if_pc_i,
   input  logic [31:0]       if_inst_i,
   output logic [REG_AW-1:0] rs1_addr_o,
   output logic [REG_AW-1:0] rs2_addr_o,
   input  logic [XLEN-1:0]   rf_rs1_data_i,
   input  logic [XLEN-1:0]   rf_rs2_data_i,
   input  logic              ex_wreg_en_i,
   input  logic [REG_AW-1:0] ex_wreg_addr_i,
   input  logic [XLEN-1:0]   ex_wreg_data_i,
   input  logic              ex_rmem_en_i,
   input  logic              mem_wreg_en_i,
   input  logic [REG_AW-1:0] mem_wreg_addr_i,
   input  logic [XLEN-1:0]   mem_wreg_data_i,
`ifdef ID_WB_FWD_EN
   input  logic              wb_wreg_en_i,
   input  logic [REG_AW-1:0] wb_wreg_addr_i,
   input  logic [XLEN-1:0]   wb_wreg_data_i,
`endif
   input  logic              ex_ready_i,
   output logic              id_valid_o,
   output logic [XLEN-1:0]   pc_o,
   output logic [6:0]        opcode_o,
   output logic [2:0]        funct3_o,
   output logic [6:0]        funct7_o,
   output logic [XLEN-1:0]   imm_o,
   output logic              wreg_en_o,
   output logic [REG_AW-1:0] wreg_addr_o,
   output logic [XLEN-1:0]   rs1_data_o,
   output logic [XLEN-1:0]   rs2_data_o,
   output logic              rmem_en_o,
   output logic              wmem_en_o,
   output logic              illegal_o
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

   if (NREGS != (1 << REG_AW)) begin : g_nregs_chk
      $error("id_pipe: NREGS must equal 2**REG_AW");
   end

   // Sign-extended immediate selected by instruction format; R-type and unknown give zero.
   function automatic logic [XLEN-1:0] imm_decode(input logic [31:0] inst);
      logic [31:0] imm32;
      case (inst[6:0])
         OPC_OPIMM, OPC_LOAD, OPC_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
         OPC_STORE:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OPC_BRANCH: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: imm32 = {inst[31:12], 12'b0};
         OPC_JAL:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:    imm32 = 32'b0;
      endcase
      return XLEN'($signed(imm32));
   endfunction

   logic [6:0]        opc_s;
   logic [REG_AW-1:0] rs1_s, rs2_s, rd_s;
   logic              rs1_used_s, rs2_used_s, wr_s, legal_s, rmem_s, wmem_s;
   logic              hazard_s, adv_s, ex_fwd_ok_s;
   logic [XLEN-1:0]   rs1_fwd_s, rs2_fwd_s;

   logic              id_valid_r;
   logic [XLEN-1:0]   pc_r, imm_r, rs1_data_r, rs2_data_r;
   logic [6:0]        opcode_r, funct7_r;
   logic [2:0]        funct3_r;
   logic              wreg_en_r, rmem_en_r, wmem_en_r, illegal_r;
   logic [REG_AW-1:0] wreg_addr_r;

   assign opc_s = if_inst_i[6:0];
   assign rs1_s = REG_AW'(if_inst_i[19:15]);
   assign rs2_s = REG_AW'(if_inst_i[24:20]);
   assign rd_s  = REG_AW'(if_inst_i[11:7]);
   assign rs1_addr_o = rs1_s;
   assign rs2_addr_o = rs2_s;

   // Per-opcode register usage and control classification.
   always_comb begin
      rs1_used_s = 1'b0;
      rs2_used_s = 1'b0;
      wr_s       = 1'b0;
      legal_s    = 1'b1;
      rmem_s     = 1'b0;
      wmem_s     = 1'b0;
      case (opc_s)
         OPC_LUI, OPC_AUIPC, OPC_JAL: wr_s = 1'b1;
         OPC_JALR: begin
            rs1_used_s = 1'b1;
            wr_s       = 1'b1;
         end
         OPC_BRANCH: begin
            rs1_used_s = 1'b1;
            rs2_used_s = 1'b1;
         end
         OPC_LOAD: begin
            rs1_used_s = 1'b1;
            wr_s       = 1'b1;
            rmem_s     = 1'b1;
         end
         OPC_STORE: begin
            rs1_used_s = 1'b1;
            rs2_used_s = 1'b1;
            wmem_s     = 1'b1;
         end
         OPC_OPIMM: begin
            rs1_used_s = 1'b1;
            wr_s       = 1'b1;
         end
         OPC_OP: begin
            rs1_used_s = 1'b1;
            rs2_used_s = 1'b1;
            wr_s       = 1'b1;
         end
         default: legal_s = 1'b0;
      endcase
   end

   // A load in EX cannot forward its data yet, so a consumer of its destination must wait.
   assign hazard_s = ex_rmem_en_i & ex_wreg_en_i & (ex_wreg_addr_i != REG_ZERO) &
                     (((ex_wreg_addr_i == rs1_s) & rs1_used_s) |
                      ((ex_wreg_addr_i == rs2_s) & rs2_used_s));
   assign adv_s       = ~id_valid_r | ex_ready_i;
   assign if_ready_o  = flush_i | (adv_s & ~hazard_s);
   assign ex_fwd_ok_s = ex_wreg_en_i & ~ex_rmem_en_i;

   // Operand 1 resolution, youngest producer first.
   always_comb begin
      if (rs1_s == REG_ZERO) begin
         rs1_fwd_s = {XLEN{1'b0}};
      end else if (ex_fwd_ok_s && (ex_wreg_addr_i == rs1_s)) begin
         rs1_fwd_s = ex_wreg_data_i;
      end else if (mem_wreg_en_i && (mem_wreg_addr_i == rs1_s)) begin
         rs1_fwd_s = mem_wreg_data_i;
`ifdef ID_WB_FWD_EN
      end else if (wb_wreg_en_i && (wb_wreg_addr_i == rs1_s)) begin
         rs1_fwd_s = wb_wreg_data_i;
`endif
      end else begin
         rs1_fwd_s = rf_rs1_data_i;
      end
   end

   // Operand 2 resolution, youngest producer first.
   always_comb begin
      if (rs2_s == REG_ZERO) begin
         rs2_fwd_s = {XLEN{1'b0}};
      end else if (ex_fwd_ok_s && (ex_wreg_addr_i == rs2_s)) begin
         rs2_fwd_s = ex_wreg_data_i;
      end else if (mem_wreg_en_i && (mem_wreg_addr_i == rs2_s)) begin
         rs2_fwd_s = mem_wreg_data_i;
`ifdef ID_WB_FWD_EN
      end else if (wb_wreg_en_i && (wb_wreg_addr_i == rs2_s)) begin
         rs2_fwd_s = wb_wreg_data_i;
`endif
      end else begin
         rs2_fwd_s = rf_rs2_data_i;
      end
   end

   // ID/EX pipeline register: flush, then bubble, then capture, else hold while EX stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid_r  <= 1'b0;
         pc_r        <= {XLEN{1'b0}};
         opcode_r    <= 7'b0;
         funct3_r    <= 3'b0;
         funct7_r    <= 7'b0;
         imm_r       <= {XLEN{1'b0}};
         wreg_en_r   <= 1'b0;
         wreg_addr_r <= REG_ZERO;
         rs1_data_r  <= {XLEN{1'b0}};
         rs2_data_r  <= {XLEN{1'b0}};
         rmem_en_r   <= 1'b0;
         wmem_en_r   <= 1'b0;
         illegal_r   <= 1'b0;
      end else if (flush_i) begin
         id_valid_r <= 1'b0;
      end else if (adv_s && hazard_s) begin
         id_valid_r <= 1'b0;
      end else if (adv_s && if_valid_i) begin
         id_valid_r  <= 1'b1;
         pc_r        <= if_pc_i;
         opcode_r    <= opc_s;
         funct3_r    <= if_inst_i[14:12];
         funct7_r    <= if_inst_i[31:25];
         imm_r       <= imm_decode(if_inst_i);
         wreg_en_r   <= wr_s & (rd_s != REG_ZERO);
         wreg_addr_r <= rd_s;
         rs1_data_r  <= rs1_fwd_s;
         rs2_data_r  <= rs2_fwd_s;
         rmem_en_r   <= rmem_s;
         wmem_en_r   <= wmem_s;
         illegal_r   <= ~legal_s;
      end else if (adv_s) begin
         id_valid_r <= 1'b0;
      end else begin
         id_valid_r <= id_valid_r;
      end
   end

   assign id_valid_o  = id_valid_r;
   assign pc_o        = pc_r;
   assign opcode_o    = opcode_r;
   assign funct3_o    = funct3_r;
   assign funct7_o    = funct7_r;
   assign imm_o       = imm_r;
   assign wreg_en_o   = wreg_en_r;
   assign wreg_addr_o = wreg_addr_r;
   assign rs1_data_o  = rs1_data_r;
   assign rs2_data_o  = rs2_data_r;
   assign rmem_en_o   = rmem_en_r;
   assign wmem_en_o   = wmem_en_r;
   assign illegal_o   = illegal_r;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: scoreboard bench for id_pipe; predicted decode results are queued when IF
// hands over an instruction and compared when the ID output register loads.
module tb_id_pipe;

   logic        clk = 1'b0;
   logic        rst_n, flush, if_valid, if_ready, id_valid;
   logic [31:0] if_pc, if_inst, rf1, rf2;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        ex_wen, ex_rmem, mem_wen, ex_ready;
   logic [4:0]  ex_addr, mem_addr;
   logic [31:0] ex_data, mem_data;
   logic [31:0] pc_o, imm_o, rs1_o, rs2_o;
   logic [6:0]  opcode_o, funct7_o;
   logic [2:0]  funct3_o;
   logic        wreg_en_o, rmem_o, wmem_o, illegal_o;
   logic [4:0]  wreg_addr_o;
`ifdef ID_WB_FWD_EN
   logic        wb_wen;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
`endif

   always #5 clk = ~clk;

   id_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .if_valid_i(if_valid), .if_ready_o(if_ready), .if_pc_i(if_pc), .if_inst_i(if_inst),
      .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
      .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2),
      .ex_wreg_en_i(ex_wen), .ex_wreg_addr_i(ex_addr), .ex_wreg_data_i(ex_data),
      .ex_rmem_en_i(ex_rmem),
      .mem_wreg_en_i(mem_wen), .mem_wreg_addr_i(mem_addr), .mem_wreg_data_i(mem_data),
`ifdef ID_WB_FWD_EN
      .wb_wreg_en_i(wb_wen), .wb_wreg_addr_i(wb_addr), .wb_wreg_data_i(wb_data),
`endif
      .ex_ready_i(ex_ready), .id_valid_o(id_valid), .pc_o(pc_o),
      .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .imm_o(imm_o),
      .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o),
      .rs1_data_o(rs1_o), .rs2_data_o(rs2_o),
      .rmem_en_o(rmem_o), .wmem_en_o(wmem_o), .illegal_o(illegal_o)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        rmem;
      logic        wmem;
      logic        ill;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   logic mdl_valid;
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 32'd0;
      if (ex_wen && !ex_rmem && ex_addr == a) return ex_data;
      if (mem_wen && mem_addr == a) return mem_data;
`ifdef ID_WB_FWD_EN
      if (wb_wen && wb_addr == a) return wb_data;
`endif
      return rf;
   endfunction

   function automatic logic model_hazard();
      logic [6:0] op;
      logic       u1, u2;
      op = if_inst[6:0];
      u1 = op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
      u2 = op inside {7'b1100011, 7'b0100011, 7'b0110011};
      return ex_rmem && ex_wen && (ex_addr != 5'd0) &&
             ((ex_addr == if_inst[19:15] && u1) || (ex_addr == if_inst[24:20] && u2));
   endfunction

   function automatic exp_t predict();
      exp_t       e;
      logic [6:0] op;
      logic [31:0] i;
      i = if_inst;
      op = i[6:0];
      e = '0;
      e.pc = if_pc;
      e.opcode = op;
      e.funct3 = i[14:12];
      e.funct7 = i[31:25];
      e.waddr = i[11:7];
      e.rs1 = resolve(i[19:15], rf1);
      e.rs2 = resolve(i[24:20], rf2);
      case (op)
         7'b0010011, 7'b0000011, 7'b1100111: e.imm = {{20{i[31]}}, i[31:20]};
         7'b0100011: e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
         7'b1100011: e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         7'b0110111, 7'b0010111: e.imm = {i[31:12], 12'h000};
         7'b1101111: e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         default: e.imm = 32'd0;
      endcase
      e.wen = (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                          7'b0010011, 7'b0110011}) && (i[11:7] != 5'd0);
      e.rmem = (op == 7'b0000011);
      e.wmem = (op == 7'b0100011);
      e.ill = !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011});
      return e;
   endfunction

   task automatic cmp_fields(input string tag, input exp_t e);
      check_val({tag, "_pc"}, pc_o, e.pc);
      check_val({tag, "_opcode"}, 32'(opcode_o), 32'(e.opcode));
      check_val({tag, "_funct3"}, 32'(funct3_o), 32'(e.funct3));
      check_val({tag, "_funct7"}, 32'(funct7_o), 32'(e.funct7));
      check_val({tag, "_imm"}, imm_o, e.imm);
      check_val({tag, "_wen"}, 32'(wreg_en_o), 32'(e.wen));
      check_val({tag, "_waddr"}, 32'(wreg_addr_o), 32'(e.waddr));
      check_val({tag, "_rs1"}, rs1_o, e.rs1);
      check_val({tag, "_rs2"}, rs2_o, e.rs2);
      check_val({tag, "_rmem"}, 32'(rmem_o), 32'(e.rmem));
      check_val({tag, "_wmem"}, 32'(wmem_o), 32'(e.wmem));
      check_val({tag, "_illegal"}, 32'(illegal_o), 32'(e.ill));
   endtask

   // One clock: check handshake at negedge, predict, then check the register after the edge.
   task automatic cycle();
      logic hz, adv, rdy, nv, load;
      @(negedge clk);
      check_val("rs1_addr", 32'(rs1_addr), 32'(if_inst[19:15]));
      check_val("rs2_addr", 32'(rs2_addr), 32'(if_inst[24:20]));
      hz = model_hazard();
      adv = !mdl_valid || ex_ready;
      rdy = flush || (adv && !hz);
      check_val("if_ready", 32'(if_ready), 32'(rdy));
      load = 1'b0;
      if (flush) nv = 1'b0;
      else if (adv && hz) nv = 1'b0;
      else if (adv && if_valid) begin
         nv = 1'b1;
         load = 1'b1;
         sb_q.push_back(predict());
      end else if (adv) nv = 1'b0;
      else nv = mdl_valid;
      @(posedge clk);
      #1;
      check_val("id_valid", 32'(id_valid), 32'(nv));
      if (load) begin
         cur = sb_q.pop_front();
         cmp_fields("load", cur);
      end else if (nv) begin
         cmp_fields("hold", cur);
      end
      mdl_valid = nv;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
      if_valid = 1'b1;
      if_pc = pc;
      if_inst = inst;
      cycle();
      if_valid = 1'b0;
   endtask

   task automatic clear_fwd();
      ex_wen = 1'b0; ex_rmem = 1'b0; ex_addr = 5'd0; ex_data = 32'd0;
      mem_wen = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
`ifdef ID_WB_FWD_EN
      wb_wen = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
`endif
   endtask

   logic [31:0] insts [8] = '{32'h00500093, 32'h002081B3, 32'hFE000EE3, 32'h0020A423,
                              32'h0040A283, 32'h123453B7, 32'h008000EF, 32'hFFFFFFFF};

   initial begin
      rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
      if_pc = 32'd0; if_inst = 32'd0; rf1 = 32'h11110000; rf2 = 32'h22220000;
      clear_fwd();
      mdl_valid = 1'b0;
      cur = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", 32'(id_valid), 32'd0);
      check_val("rst_pc", pc_o, 32'd0);
      check_val("rst_imm", imm_o, 32'd0);
      check_val("rst_wen", 32'(wreg_en_o), 32'd0);
      check_val("rst_rs1", rs1_o, 32'd0);
      rst_n = 1'b1;

      issue(32'h100, 32'h00500093);
      check_val("addi_valid", 32'(id_valid), 32'd1);
      check_val("addi_imm", imm_o, 32'd5);
      check_val("addi_waddr", 32'(wreg_addr_o), 32'd1);
      check_val("addi_wen", 32'(wreg_en_o), 32'd1);
      check_val("addi_pc", pc_o, 32'h100);

      ex_wen = 1'b1; ex_addr = 5'd1; ex_data = 32'hAA;
      mem_wen = 1'b1; mem_addr = 5'd1; mem_data = 32'hBB;
      issue(32'h104, 32'h002081B3);
      check_val("fwd_ex", rs1_o, 32'hAA);
      ex_wen = 1'b0;
      issue(32'h108, 32'h002081B3);
      check_val("fwd_mem", rs1_o, 32'hBB);
      clear_fwd();
      issue(32'h10C, 32'h002081B3);
      check_val("fwd_rf", rs1_o, 32'h11110000);

      ex_wen = 1'b1; ex_rmem = 1'b1; ex_addr = 5'd1; ex_data = 32'hDEAD;
      if_valid = 1'b1; if_pc = 32'h110; if_inst = 32'h002081B3;
      cycle();
      check_val("lu_bubble", 32'(id_valid), 32'd0);
      clear_fwd();
      cycle();
      check_val("lu_capture_pc", pc_o, 32'h110);
      ex_wen = 1'b1; ex_rmem = 1'b1; ex_addr = 5'd0;
      issue(32'h114, 32'h002081B3);
      ex_addr = 5'd5;
      issue(32'h118, 32'h00500093);
      check_val("lu_rs2_unused", 32'(id_valid), 32'd1);
      clear_fwd();

      issue(32'h200, 32'h0020A423);
      ex_ready = 1'b0;
      if_valid = 1'b1; if_pc = 32'h204; if_inst = 32'h0040A283;
      repeat (3) cycle();
      check_val("stall_pc", pc_o, 32'h200);
      ex_ready = 1'b1;
      cycle();
      check_val("stall_release_pc", pc_o, 32'h204);

      flush = 1'b1; if_pc = 32'h208; if_inst = 32'h123453B7;
      cycle();
      check_val("flush_valid", 32'(id_valid), 32'd0);
      flush = 1'b0;

      issue(32'h300, 32'hFFFFFFFF);
      check_val("ill_flag", 32'(illegal_o), 32'd1);
      check_val("ill_wen", 32'(wreg_en_o), 32'd0);
      check_val("ill_valid", 32'(id_valid), 32'd1);
      issue(32'h304, 32'hFE000EE3);
      check_val("beq_imm", imm_o, 32'hFFFFFFFC);
      issue(32'h308, 32'h123453B7);
      check_val("lui_imm", imm_o, 32'h12345000);
      issue(32'h30C, 32'h008000EF);
      check_val("jal_imm", imm_o, 32'd8);

      issue(32'h400, 32'h00500093);
      ex_ready = 1'b0;
      if_valid = 1'b1; if_pc = 32'h404; if_inst = 32'h002081B3;
      cycle();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", 32'(id_valid), 32'd0);
      check_val("mid_rst_pc", pc_o, 32'd0);
      check_val("mid_rst_wen", 32'(wreg_en_o), 32'd0);
      mdl_valid = 1'b0;
      sb_q.delete();
      if_valid = 1'b0; ex_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      check_val("post_rst_valid", 32'(id_valid), 32'd0);

      for (int n = 0; n < 300; n++) begin
         if_inst = insts[$urandom_range(0, 7)];
         if (if_inst != 32'hFFFFFFFF) begin
            if_inst[11:7] = 5'($urandom_range(0, 3));
            if_inst[19:15] = 5'($urandom_range(0, 3));
            if_inst[24:20] = 5'($urandom_range(0, 3));
         end
         if_pc = $urandom;
         if_valid = ($urandom_range(0, 9) < 7);
         ex_ready = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 9) == 0);
         rf1 = $urandom; rf2 = $urandom;
         ex_wen = $urandom_range(0, 1); ex_rmem = ($urandom_range(0, 3) == 0);
         ex_addr = 5'($urandom_range(0, 3)); ex_data = $urandom;
         mem_wen = $urandom_range(0, 1);
         mem_addr = 5'($urandom_range(0, 3)); mem_data = $urandom;
`ifdef ID_WB_FWD_EN
         wb_wen = $urandom_range(0, 1);
         wb_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
`endif
         cycle();
      end
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
